// File: rtl/pe_data_mover.sv
// BRAM port-B data mover: streams load bursts to a masked set of PE lanes and
// writes PE results back in lane order. Optional DF_STRIDE_EN adds a per-command address stride.
module pe_data_mover #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 17,
    parameter int NUM_PE    = 4,
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 1,
    localparam int LEN_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic                     CMD_OP,
    input  logic [ADDR_W-1:0]        CMD_ADDR,
    input  logic [LEN_W-1:0]         CMD_LEN,
    input  logic [NUM_PE-1:0]        CMD_PE_MASK,
`ifdef DF_STRIDE_EN
    input  logic [ADDR_W-1:0]        CMD_STRIDE,
`endif
    output logic                     DONE,
    output logic [31:0]              addrb,
    output logic [DATA_W-1:0]        dinb,
    input  logic [DATA_W-1:0]        doutb,
    output logic                     enb,
    output logic [DATA_W/8-1:0]      web,
    output logic [DATA_W-1:0]        PE_DIN,
    output logic [NUM_PE-1:0]        PE_DIN_VALID,
    output logic [LEN_W-1:0]         PE_DIN_IDX,
    input  logic [NUM_PE*DATA_W-1:0] PE_DOUT
);

    // state | meaning
    // IDLE  | ready for a command
    // LOAD  | issuing BRAM reads, one word per cycle
    // DRAIN | waiting for outstanding reads to return
    // STORE | writing PE lane words to BRAM
    // FIN   | DONE pulse
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam int LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_step;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_k;
    logic [NUM_PE-1:0] r_mask;
    logic [LANE_W-1:0] r_lane;
    logic              r_ready;
    logic              r_done;
    logic [RD_LAT-1:0] r_vld;
    logic [LEN_W-1:0]  r_idx [RD_LAT];
    logic              w_accept;
    logic              w_last;
    logic              w_pending;
    logic              w_access;
    logic              w_store;
    logic [DATA_W-1:0] w_lane_word;

`ifdef DF_STRIDE_EN
    logic [ADDR_W-1:0] r_stride;
    assign w_step = r_stride;
`else
    assign w_step = ADDR_W'(1);
`endif

    assign w_accept = CMD_VALID & r_ready;
    assign w_last   = (r_k == r_len - LEN_W'(1));
    assign w_store  = (r_state == S_STORE);
    assign w_access = (r_state == S_LOAD) | w_store;

    // Reads still upstream of the output stage keep DRAIN alive.
    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            w_pending = w_pending | r_vld[i];
        end
    end

    always_comb begin
        w_lane_word = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_lane_word = PE_DOUT[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (CMD_LEN == '0) begin
                        w_state_nxt = S_FIN;
                    end else if (CMD_OP) begin
                        w_state_nxt = S_STORE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD:  if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!w_pending) w_state_nxt = S_FIN;
            S_STORE: if (w_last) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_k     <= '0;
            r_mask  <= '0;
            r_lane  <= '0;
`ifdef DF_STRIDE_EN
            r_stride <= '0;
`endif
            r_vld   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_done  <= (w_state_nxt == S_FIN);
            if (w_accept) begin
                r_addr <= CMD_ADDR;
                r_len  <= CMD_LEN;
                r_mask <= CMD_PE_MASK;
                r_k    <= '0;
                r_lane <= '0;
`ifdef DF_STRIDE_EN
                r_stride <= CMD_STRIDE;
`endif
            end else if (w_access) begin
                // Running address avoids a k*stride multiplier; wrap is modulo 2^ADDR_W.
                r_addr <= r_addr + w_step;
                r_k    <= r_k + LEN_W'(1);
                r_lane <= (r_lane == LANE_W'(NUM_PE - 1)) ? '0 : r_lane + LANE_W'(1);
            end
            r_vld[0] <= (r_state == S_LOAD);
            r_idx[0] <= (r_state == S_LOAD) ? r_k : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign CMD_READY    = r_ready;
    assign DONE         = r_done;
    assign enb          = w_access;
    assign addrb        = w_access ? 32'(r_addr) : 32'd0;
    assign web          = w_store ? {(DATA_W/8){1'b1}} : '0;
    assign dinb         = w_store ? w_lane_word : '0;
    assign PE_DIN       = r_vld[RD_LAT-1] ? doutb : '0;
    assign PE_DIN_VALID = r_vld[RD_LAT-1] ? r_mask : '0;
    assign PE_DIN_IDX   = r_idx[RD_LAT-1];

endmodule

// File: tb/tb_pe_data_mover.sv
// Randomized bench for pe_data_mover: per-cycle expected-output timeline built from
// the command rules, a synchronous BRAM model, and a few hand-computed pins.
module tb_pe_data_mover;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 17;
    localparam int NUM_PE    = 4;
    localparam int MAX_BURST = 16;
    localparam int RD_LAT    = 1;
    localparam int LEN_W     = $clog2(MAX_BURST + 1);
    localparam int AMASK     = (1 << ADDR_W) - 1;

    logic                     CLK = 1'b0;
    logic                     RSTN = 1'b0;
    logic                     CMD_VALID = 1'b0;
    logic                     CMD_READY;
    logic                     CMD_OP = 1'b0;
    logic [ADDR_W-1:0]        CMD_ADDR = '0;
    logic [LEN_W-1:0]         CMD_LEN = '0;
    logic [NUM_PE-1:0]        CMD_PE_MASK = '0;
`ifdef DF_STRIDE_EN
    logic [ADDR_W-1:0]        CMD_STRIDE = '0;
`endif
    logic                     DONE;
    logic [31:0]              addrb;
    logic [DATA_W-1:0]        dinb;
    logic [DATA_W-1:0]        doutb;
    logic                     enb;
    logic [DATA_W/8-1:0]      web;
    logic [DATA_W-1:0]        PE_DIN;
    logic [NUM_PE-1:0]        PE_DIN_VALID;
    logic [LEN_W-1:0]         PE_DIN_IDX;
    logic [NUM_PE*DATA_W-1:0] PE_DOUT = '0;

    pe_data_mover #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PE(NUM_PE),
        .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .CMD_PE_MASK(CMD_PE_MASK),
`ifdef DF_STRIDE_EN
        .CMD_STRIDE(CMD_STRIDE),
`endif
        .DONE(DONE), .addrb(addrb), .dinb(dinb), .doutb(doutb), .enb(enb), .web(web),
        .PE_DIN(PE_DIN), .PE_DIN_VALID(PE_DIN_VALID), .PE_DIN_IDX(PE_DIN_IDX), .PE_DOUT(PE_DOUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    // Synchronous BRAM with RD_LAT cycles of read latency; garbage when not reading.
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    logic [31:0] bram [int unsigned];
    always @(posedge CLK) begin
        if (enb && web != '0) bram[addrb] = dinb;
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (enb && web == '0)
            rd_pipe[0] <= bram.exists(addrb) ? bram[addrb] : init_word(addrb);
        else
            rd_pipe[0] <= $urandom;
    end
    assign doutb = rd_pipe[RD_LAT-1];

    // Expected outputs, keyed by the edge that ends the cycle in which they hold.
    typedef struct {
        logic                  enb;
        logic [31:0]           addrb;
        logic [DATA_W/8-1:0]   web;
        logic [DATA_W-1:0]     dinb;
        logic [DATA_W-1:0]     pe_din;
        logic [NUM_PE-1:0]     pe_vld;
        logic [LEN_W-1:0]      pe_idx;
        logic                  done;
        logic                  ready;
    } exp_t;

    exp_t exp_q [int];
    logic [31:0] ref_mem [int unsigned];
    int next_ok = 0;
    bit checking = 0;

    function automatic exp_t get_exp(input int e);
        exp_t x;
        if (exp_q.exists(e)) return exp_q[e];
        x.enb = 0; x.addrb = '0; x.web = '0; x.dinb = '0; x.pe_din = '0;
        x.pe_vld = '0; x.pe_idx = '0; x.done = 0; x.ready = 1;
        return x;
    endfunction

    function automatic logic [31:0] ref_read(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic model_cmd(input int a, input bit op, input int addr, input int len,
                             input int mask, input int stride,
                             input logic [NUM_PE*DATA_W-1:0] pd);
        exp_t x;
        int last;
        int unsigned ad;
        if (len == 0) last = 1;
        else if (op) last = len + 1;
        else last = len + RD_LAT + 1;
        for (int n = 1; n <= last; n++) begin
            x = get_exp(a + n); x.ready = 0; exp_q[a + n] = x;
        end
        x = get_exp(a + last); x.done = 1; exp_q[a + last] = x;
        for (int k = 0; k < len; k++) begin
            ad = (addr + k * stride) & AMASK;
            x = get_exp(a + 1 + k);
            x.enb = 1; x.addrb = ad;
            if (op) begin
                x.web = '1;
                x.dinb = pd[(k % NUM_PE) * DATA_W +: DATA_W];
                ref_mem[ad] = x.dinb;
                exp_q[a + 1 + k] = x;
            end else begin
                exp_q[a + 1 + k] = x;
                x = get_exp(a + 1 + k + RD_LAT);
                x.pe_din = ref_read(ad);
                x.pe_vld = NUM_PE'(mask);
                x.pe_idx = LEN_W'(k);
                exp_q[a + 1 + k + RD_LAT] = x;
            end
        end
        next_ok = a + last + 1;
    endtask

    always @(negedge CLK) begin : compare
        exp_t x;
        int e;
        if (checking) begin
            e = cyc + 1;
            x = get_exp(e);
            chk("CMD_READY", CMD_READY, x.ready);
            chk("DONE", DONE, x.done);
            chk("enb", enb, x.enb);
            chk("addrb", addrb, x.addrb);
            chk("web", web, x.web);
            chk("dinb", dinb, x.dinb);
            chk("PE_DIN", PE_DIN, x.pe_din);
            chk("PE_DIN_VALID", PE_DIN_VALID, x.pe_vld);
            chk("PE_DIN_IDX", PE_DIN_IDX, x.pe_idx);
            exp_q.delete(e);
        end
    end

    // Issue one command; junk VALID is driven while the mover is still busy.
    task automatic send(input bit op, input int addr, input int len, input int mask,
                        input int stride, input logic [NUM_PE*DATA_W-1:0] pd, output int a);
        int eff_stride;
        while (cyc + 1 < next_ok) begin
            CMD_VALID   = ($urandom_range(0, 2) == 0);
            CMD_OP      = 1'($urandom);
            CMD_ADDR    = ADDR_W'($urandom);
            CMD_LEN     = LEN_W'($urandom_range(0, MAX_BURST));
            CMD_PE_MASK = NUM_PE'($urandom);
            @(posedge CLK); #2;
        end
`ifdef DF_STRIDE_EN
        CMD_STRIDE = ADDR_W'(stride);
        eff_stride = stride;
`else
        eff_stride = 1;
`endif
        CMD_VALID = 1; CMD_OP = op; CMD_ADDR = ADDR_W'(addr);
        CMD_LEN = LEN_W'(len); CMD_PE_MASK = NUM_PE'(mask); PE_DOUT = pd;
        a = cyc + 1;
        model_cmd(a, op, addr, len, mask, eff_stride, pd);
        @(posedge CLK); #2;
        CMD_VALID = 0;
    endtask

    task automatic wait_to(input int e);
        while (cyc + 1 < e) begin
            @(posedge CLK); #2;
        end
    endtask

    task automatic idle_cycles(input int n);
        CMD_VALID = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #2;
        end
    endtask

    task automatic reset_pulse(input int hold);
        RSTN = 1;
        exp_q.delete();
        next_ok = 1 << 30;
        #1;
        chk("rst_enb", enb, 1'b0);
        chk("rst_addrb", addrb, 32'h0);
        chk("rst_pe_valid", PE_DIN_VALID, 4'b0000);
        chk("rst_ready", CMD_READY, 1'b1);
        chk("rst_done", DONE, 1'b0);
        #1;
        CMD_VALID = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #2;
        end
        RSTN = 0;
        next_ok = cyc + 1;
    endtask

    function automatic logic [NUM_PE*DATA_W-1:0] rand_pd();
        logic [NUM_PE*DATA_W-1:0] v;
        for (int i = 0; i < NUM_PE; i++) v[i*DATA_W +: DATA_W] = $urandom;
        return v;
    endfunction

    initial begin
        int a;
        int len;
        int addr;
        logic [NUM_PE*DATA_W-1:0] pd;
        #1 RSTN = 1;
        checking = 1;
        @(posedge CLK); @(posedge CLK); #2;
        RSTN = 0;
        next_ok = cyc + 1;
        chk("reset_ready", CMD_READY, 1'b1);
        chk("reset_addrb", addrb, 32'h0);

        // Load 0x100, LEN=4, mask 0101.
        send(0, 32'h100, 4, 4'b0101, 1, '0, a);
        wait_to(a + 1); chk("ld_addr_c1", addrb, 32'h100);
        wait_to(a + 2); chk("ld_vld_c2", PE_DIN_VALID, 4'b0101); chk("ld_idx_c2", PE_DIN_IDX, 0);
        chk("ld_data_c2", PE_DIN, init_word(32'h100));
        wait_to(a + 4); chk("ld_addr_c4", addrb, 32'h103);
        wait_to(a + 5); chk("ld_idx_c5", PE_DIN_IDX, 3);
        wait_to(a + 6); chk("ld_done_c6", DONE, 1'b1);
        wait_to(a + 7); chk("ld_ready_c7", CMD_READY, 1'b1);

        // Store LEN=6 with lanes A,B,C,D.
        pd = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        send(1, 32'h200, 6, 4'hF, 1, pd, a);
        wait_to(a + 1); chk("st_din_c1", dinb, 32'hAAAA0001); chk("st_web_c1", web, 4'hF);
        wait_to(a + 5); chk("st_din_c5", dinb, 32'hAAAA0001); chk("st_addr_c5", addrb, 32'h204);
        wait_to(a + 6); chk("st_din_c6", dinb, 32'hBBBB0002);
        wait_to(a + 7); chk("st_done_c7", DONE, 1'b1);

        // Read back what was stored.
        send(0, 32'h202, 3, 4'b1000, 1, '0, a);
        wait_to(a + 2); chk("rb_data", PE_DIN, 32'hCCCC0003);

        // LEN=0.
        send(0, 32'h50, 0, 4'hF, 1, '0, a);
        wait_to(a + 1); chk("len0_done", DONE, 1'b1); chk("len0_enb", enb, 1'b0);

        // Address wrap.
        send(0, 32'h1FFFE, 4, 4'h3, 1, '0, a);
        wait_to(a + 2); chk("wrap_c2", addrb, 32'h1FFFF);
        wait_to(a + 3); chk("wrap_c3", addrb, 32'h0);
        wait_to(a + 4); chk("wrap_c4", addrb, 32'h1);

        // Reset in cycle 3 of a LEN=16 load, then a fresh command.
        send(0, 32'h300, 16, 4'hF, 1, '0, a);
        wait_to(a + 3);
        reset_pulse(3);
        send(0, 32'h400, 2, 4'h2, 1, '0, a);
        wait_to(a + 1); chk("post_rst_addr", addrb, 32'h400);
        wait_to(a + 2); chk("post_rst_vld", PE_DIN_VALID, 4'h2);

`ifdef DF_STRIDE_EN
        send(0, 32'h600, 3, 4'h1, 4, '0, a);
        wait_to(a + 2); chk("stride_c2", addrb, 32'h604);
        wait_to(a + 3); chk("stride_c3", addrb, 32'h608);
`endif

        for (int it = 0; it < 250; it++) begin
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : $urandom_range(0, MAX_BURST);
            case ($urandom_range(0, 3))
                0: addr = AMASK - $urandom_range(0, 8);
                1: addr = $urandom_range(0, 40);
                default: addr = $urandom_range(0, AMASK);
            endcase
            send(1'($urandom), addr, len, $urandom_range(0, 15), $urandom_range(0, 5), rand_pd(), a);
            if ($urandom_range(0, 24) == 0 && len > 1) begin
                wait_to(a + $urandom_range(1, len));
                reset_pulse($urandom_range(1, 3));
            end else if ($urandom_range(0, 2) == 0) begin
                wait_to(next_ok);
                idle_cycles($urandom_range(0, 3));
            end
        end

        wait_to(next_ok);
        idle_cycles(3);
        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1);
    end

endmodule
